dpath_ld_arb: RTL

Load arbiter and scan sequencer for one shared N-bit datapath hold register (hold/scan flip-flop bank). Two requesters compete to load the register, with round-robin fairness. A scan requester can take the register over for an N-cycle serial shift. The block drives the register's D, HOLD, TEST and SCANIN pins and returns grants and scan status to the requesters.

---
 rtl/dpath_ld_arb.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dpath_ld_arb.sv
// Load arbiter and scan sequencer for a shared N-bit hold/scan register bank.
// Two round-robin load requesters share the register; a scan request takes it over for N shift cycles.
module dpath_ld_arb #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         REQ0,
  input  logic [N-1:0] D0,
  input  logic         REQ1,
  input  logic [N-1:0] D1,
  input  logic         SCAN_REQ,
  input  logic         SCAN_DIN,
  output logic         GNT0,
  output logic         GNT1,
  output logic [N-1:0] DOUT,
  output logic         HOLD_OUT,
  output logic         TEST_OUT,
  output logic         SCANIN_OUT,
  output logic         SCAN_DONE,
  output logic         BUSY
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           gnt0_q, gnt0_d;
  logic           gnt1_q, gnt1_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           hold_q, hold_d;
  logic           test_q, test_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           elig0, elig1;

  // A requester granted last cycle is masked so it cannot win twice in a row.
  assign elig0 = REQ0 & ~gnt0_q;
  assign elig1 = REQ1 & ~gnt1_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    dout_d  = dout_q;
    hold_d  = 1'b1;
    test_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (SCAN_REQ) begin
          state_d = SCAN;
          cnt_d   = '0;
          test_d  = 1'b1;
          hold_d  = 1'b0;
        end else if (elig0 && (!elig1 || last_q)) begin
          gnt0_d  = 1'b1;
          dout_d  = D0;
          hold_d  = 1'b0;
          last_d  = 1'b0;
        end else if (elig1) begin
          gnt1_d  = 1'b1;
          dout_d  = D1;
          hold_d  = 1'b0;
          last_d  = 1'b1;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          test_d  = 1'b1;
          hold_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      dout_q  <= '0;
      hold_q  <= 1'b1;
      test_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      dout_q  <= dout_d;
      hold_q  <= hold_d;
      test_q  <= test_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT0       = gnt0_q;
  assign GNT1       = gnt1_q;
  assign DOUT       = dout_q;
  assign HOLD_OUT   = hold_q;
  assign TEST_OUT   = test_q;
  assign SCANIN_OUT = SCAN_DIN & test_q;
  assign SCAN_DONE  = done_q;
  assign BUSY       = busy_q;

endmodule
